// File: rtl/nand_seq_pkg.sv
// Shared types and helpers for the NAND truth-table sequencer.
// Holds the FSM state encoding, default parameters and the reference NAND function.
package nand_seq_pkg;

  localparam int DEF_N_IN          = 2;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int MAX_N_IN          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bits at or above n_in are forced to 1 so they cannot affect the AND reduction.
  function automatic logic expected_nand(input logic [MAX_N_IN-1:0] row, input int n_in);
    logic [MAX_N_IN-1:0] padded;
    padded = row;
    for (int i = 0; i < MAX_N_IN; i++) begin
      if (i >= n_in) padded[i] = 1'b1;
    end
    return ~&padded;
  endfunction

endpackage

// File: rtl/nand_seq_settle_cnt.sv
// Loadable down-counter that times how long each truth-table row is held before sampling.
// at_one_o flags the last settle cycle so the sequencer can move to SAMPLE.
module nand_seq_settle_cnt #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CW            = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic at_one_o
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_one_o = (cnt_q == ONE);

endmodule

// File: rtl/nand_truth_sequencer.sv
// Clocked harness that walks a gate through every truth-table row and checks it against NAND.
// Handshake: start is a level sampled on a rising edge; it is accepted only in IDLE or DONE.
module nand_truth_sequencer
  import nand_seq_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] drive,
  input  logic            dut_s,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            mismatch,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_row,
  output state_t          state
);

  localparam logic [N_IN-1:0] LAST_ROW = '1;
  localparam logic [N_IN-1:0] ROW_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] row_q, row_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffr_q, ffr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mis_q, mis_d;
  logic            fv_q, fv_d;

  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_at_one;
  logic            exp_s;
  logic            sample_fail;

  nand_seq_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cnt_load),
    .dec_i   (cnt_dec),
    .at_one_o(cnt_at_one)
  );

  // Expected value comes from the row register so it never depends on the driven bus.
  assign exp_s       = expected_nand(MAX_N_IN'(row_q), N_IN);
  assign sample_fail = (dut_s !== exp_s);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    err_d    = err_q;
    ffr_d    = ffr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mis_d    = 1'b0;
    fv_d     = fv_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          row_d    = '0;
          err_d    = '0;
          ffr_d    = '0;
          fv_d     = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_at_one) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (sample_fail) begin
          err_d = err_q + ERR_ONE;
          mis_d = 1'b1;
          if (!fv_q) begin
            ffr_d = row_q;
            fv_d  = 1'b1;
          end
        end
        // Pass uses the updated count so the final row's result is included.
        if (row_q == LAST_ROW) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          row_d    = row_q + ROW_ONE;
          cnt_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      err_q   <= '0;
      ffr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= err_d;
      ffr_q   <= ffr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
      fv_q    <= fv_d;
    end
  end

  // The row register doubles as the stimulus bus; it only moves on start or SAMPLE edges.
  assign drive          = row_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign mismatch       = mis_q;
  assign fail_valid     = fv_q;
  assign first_fail_row = ffr_q;
  assign state          = state_q;

endmodule

// File: tb/tb_nand_truth_sequencer.sv
// Directed bench for nand_truth_sequencer: default 2-input instance with selectable gate models
// and a 3-input, 3-settle-cycle instance driven by a real 3-input NAND.
module tb_nand_truth_sequencer;
  import nand_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start3;
  logic [1:0] mode;

  logic [1:0] drive;
  logic       dut_s;
  logic       busy, done, pass, mismatch, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail_row;
  state_t     state;

  logic [2:0] drive3;
  logic       dut_s3;
  logic       busy3, done3, pass3, mismatch3, fail_valid3;
  logic [3:0] err_count3;
  logic [2:0] first_fail_row3;
  state_t     state3;

  int tests;
  int failed;

  nand_truth_sequencer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .drive         (drive),
    .dut_s         (dut_s),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .mismatch      (mismatch),
    .fail_valid    (fail_valid),
    .first_fail_row(first_fail_row),
    .state         (state)
  );

  nand_truth_sequencer #(
    .N_IN         (3),
    .SETTLE_CYCLES(3)
  ) u_dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start3),
    .drive         (drive3),
    .dut_s         (dut_s3),
    .busy          (busy3),
    .done          (done3),
    .pass          (pass3),
    .err_count     (err_count3),
    .mismatch      (mismatch3),
    .fail_valid    (fail_valid3),
    .first_fail_row(first_fail_row3),
    .state         (state3)
  );

  // Gate models: 0 NAND, 1 tied low, 2 AND, 3 tied high.
  always_comb begin
    dut_s = ~&drive;
    case (mode)
      2'd0: dut_s = ~&drive;
      2'd1: dut_s = 1'b0;
      2'd2: dut_s = &drive;
      2'd3: dut_s = 1'b1;
      default: dut_s = ~&drive;
    endcase
  end
  assign dut_s3 = ~&drive3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " drive"}, 32'(drive), 32'(0));
    check({tag, " busy"}, 32'(busy), 32'(0));
    check({tag, " done"}, 32'(done), 32'(0));
    check({tag, " pass"}, 32'(pass), 32'(0));
    check({tag, " err_count"}, 32'(err_count), 32'(0));
    check({tag, " mismatch"}, 32'(mismatch), 32'(0));
    check({tag, " fail_valid"}, 32'(fail_valid), 32'(0));
    check({tag, " first_fail_row"}, 32'(first_fail_row), 32'(0));
    check({tag, " state"}, 32'(state), 32'(IDLE));
    check({tag, " drive3"}, 32'(drive3), 32'(0));
    check({tag, " busy3"}, 32'(busy3), 32'(0));
    check({tag, " done3"}, 32'(done3), 32'(0));
  endtask

  // One sweep of the default instance. fail_mask bit r is set when row r should mismatch.
  // poke_j >= 0 raises start for the cycle following edge k+poke_j (start while busy).
  task automatic run_sweep(input string tag, input logic [1:0] gate, input int exp_err,
                           input int exp_ffr, input logic exp_fv, input logic [3:0] fail_mask,
                           input int poke_j);
    logic exp_mis;
    mode  = gate;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " k err_cleared"}, 32'(err_count), 32'(0));
    check({tag, " k fail_valid_cleared"}, 32'(fail_valid), 32'(0));
    check({tag, " k pass_cleared"}, 32'(pass), 32'(0));
    check({tag, " k state"}, 32'(state), 32'(SETTLE));
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      exp_mis = (j >= 2 && (j % 2) == 0) ? fail_mask[j/2-1] : 1'b0;
      check($sformatf("%s k+%0d drive", tag, j), 32'(drive), 32'(j / 2));
      check($sformatf("%s k+%0d busy", tag, j), 32'(busy), 32'(1));
      check($sformatf("%s k+%0d done", tag, j), 32'(done), 32'(0));
      check($sformatf("%s k+%0d mismatch", tag, j), 32'(mismatch), 32'(exp_mis));
      start = (j == poke_j);
    end
    step();
    check({tag, " k+8 done"}, 32'(done), 32'(1));
    check({tag, " k+8 busy"}, 32'(busy), 32'(0));
    check({tag, " k+8 pass"}, 32'(pass), 32'(exp_err == 0));
    check({tag, " k+8 err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, " k+8 fail_valid"}, 32'(fail_valid), 32'(exp_fv));
    check({tag, " k+8 first_fail_row"}, 32'(first_fail_row), 32'(exp_ffr));
    check({tag, " k+8 mismatch"}, 32'(mismatch), 32'(fail_mask[3]));
    check({tag, " k+8 drive"}, 32'(drive), 32'(3));
    check({tag, " k+8 state"}, 32'(state), 32'(DONE));
    step();
    check({tag, " k+9 mismatch"}, 32'(mismatch), 32'(0));
    check({tag, " k+9 done held"}, 32'(done), 32'(1));
    check({tag, " k+9 drive held"}, 32'(drive), 32'(3));
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 2'd0;
    #1;
    check_reset_values("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_reset_values("post_release");

    // Real NAND: clean sweep.
    run_sweep("nand", 2'd0, 0, 0, 1'b0, 4'b0000, -1);
    // Tied low: rows 0..2 fail, row 3 (expected 0) passes. Restarts straight from DONE.
    run_sweep("tie0", 2'd1, 3, 0, 1'b1, 4'b0111, -1);
    // AND gate: every row is inverted.
    run_sweep("and", 2'd2, 4, 0, 1'b1, 4'b1111, -1);
    // Tied high: only the all-ones row fails, so the first failing row is 3.
    run_sweep("tie1", 2'd3, 1, 3, 1'b1, 4'b1000, -1);
    // Start pulsed at edge k+3 while busy must not disturb the sweep.
    run_sweep("busy_start", 2'd0, 0, 0, 1'b0, 4'b0000, 2);
    // Restart from DONE after a failing sweep clears the stale error state.
    run_sweep("tie0b", 2'd1, 3, 0, 1'b1, 4'b0111, -1);
    run_sweep("rerun", 2'd0, 0, 0, 1'b0, 4'b0000, -1);

    // Asynchronous reset between edges k+5 and k+6 of a tied-low sweep.
    mode  = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 4; j++) step();
    check("midreset pre drive", 32'(drive), 32'(2));
    check("midreset pre err_count", 32'(err_count), 32'(2));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    step();
    rst_n = 1'b1;
    step();
    check("midreset release state", 32'(state), 32'(IDLE));
    check("midreset release done", 32'(done), 32'(0));
    run_sweep("after_reset", 2'd0, 0, 0, 1'b0, 4'b0000, -1);

    // Three-input instance: 8 rows at 4 cycles each.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j > 0) step();
      check($sformatf("n3 k+%0d drive3", j), 32'(drive3), 32'(j / 4));
      check($sformatf("n3 k+%0d busy3", j), 32'(busy3), 32'(1));
      check($sformatf("n3 k+%0d mismatch3", j), 32'(mismatch3), 32'(0));
      check($sformatf("n3 k+%0d done3", j), 32'(done3), 32'(0));
    end
    step();
    check("n3 k+32 done3", 32'(done3), 32'(1));
    check("n3 k+32 pass3", 32'(pass3), 32'(1));
    check("n3 k+32 busy3", 32'(busy3), 32'(0));
    check("n3 k+32 err_count3", 32'(err_count3), 32'(0));
    check("n3 k+32 fail_valid3", 32'(fail_valid3), 32'(0));
    check("n3 k+32 first_fail_row3", 32'(first_fail_row3), 32'(0));
    check("n3 k+32 drive3", 32'(drive3), 32'(7));
    check("n3 k+32 state3", 32'(state3), 32'(DONE));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
